// File: rtl/led_sequencer_if.sv
// Control and pattern-output bundle for led_sequencer.
// The master drives the controls and observes the LED outputs; the slave is the sequencer.
interface led_sequencer_if #(
  parameter int LED_WIDTH = 4
);
  logic                 i_enable;
  logic [1:0]           i_speed;
  logic [1:0]           i_mode;
  logic [1:0]           i_color;
  logic [LED_WIDTH-1:0] o_led;
  logic [LED_WIDTH-1:0] o_led_b;
  logic [LED_WIDTH-1:0] o_led_g;
  logic                 o_tick;

  modport master (
    output i_enable, i_speed, i_mode, i_color,
    input  o_led, o_led_b, o_led_g, o_tick
  );

  modport slave (
    input  i_enable, i_speed, i_mode, i_color,
    output o_led, o_led_b, o_led_g, o_tick
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: a prescaler selects the step rate, and each step rotates,
// ping-pongs or flashes a pattern that is routed to the selected colour channels.
module led_sequencer #(
  parameter int          LED_WIDTH  = 4,
  parameter int          DATA_WIDTH = 14,
  parameter int unsigned LIMIT0     = 2**14 - 1,
  parameter int unsigned LIMIT1     = 2**13 - 1,
  parameter int unsigned LIMIT2     = 2**12 - 1,
  parameter int unsigned LIMIT3     = 2**11 - 1
) (
  input  logic          clock,
  input  logic          i_reset,
  led_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ROT_L     = 2'b00,
    MODE_ROT_R     = 2'b01,
    MODE_PING_PONG = 2'b10,
    MODE_FLASH     = 2'b11
  } mode_t;

  typedef enum logic {
    PP_LEFT  = 1'b0,
    PP_RIGHT = 1'b1
  } pp_state_t;

  logic [DATA_WIDTH-1:0] count_data;
  logic [DATA_WIDTH-1:0] limit_sel;
  logic                  tick_q;
  logic                  step;

  logic [LED_WIDTH-1:0]  pattern;
  logic [LED_WIDTH-1:0]  pattern_next;
  pp_state_t             pp_state;
  pp_state_t             pp_state_next;
  logic                  one_hot;
  logic                  go_left;
  mode_t                 mode;

  always_comb begin
    unique case (bus.i_speed)
      2'd0:    limit_sel = DATA_WIDTH'(LIMIT0);
      2'd1:    limit_sel = DATA_WIDTH'(LIMIT1);
      2'd2:    limit_sel = DATA_WIDTH'(LIMIT2);
      default: limit_sel = DATA_WIDTH'(LIMIT3);
    endcase
  end

  // >= rather than == so that dropping to a lower limit mid-count ends the period at once.
  assign step = bus.i_enable && (count_data >= limit_sel);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count_data <= '0;
      tick_q     <= 1'b0;
    end else if (bus.i_enable) begin
      if (step) begin
        count_data <= '0;
        tick_q     <= 1'b1;
      end else begin
        count_data <= count_data + DATA_WIDTH'(1);
        tick_q     <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  // NOTE: only the pattern and FSM are reset here; they are plain flops, so reset is cheap and defines the first frame.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      pattern  <= LED_WIDTH'(1);
      pp_state <= PP_LEFT;
    end else if (step) begin
      pattern  <= pattern_next;
      pp_state <= pp_state_next;
    end
  end

  assign mode    = mode_t'(bus.i_mode);
  assign one_hot = (pattern != '0) && ((pattern & (pattern - LED_WIDTH'(1))) == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pattern_next  = pattern;
    pp_state_next = pp_state;
    go_left       = 1'b0;

    if (mode == MODE_FLASH) begin
      pattern_next = (pattern == '1) ? '0 : '1;
    end else if (!one_hot) begin
      pattern_next  = LED_WIDTH'(1);
      pp_state_next = PP_LEFT;
    end else begin
      unique case (mode)
        MODE_ROT_L: pattern_next = (pattern << 1) | (pattern >> (LED_WIDTH - 1));
        MODE_ROT_R: pattern_next = (pattern >> 1) | (pattern << (LED_WIDTH - 1));
        MODE_PING_PONG: begin
          if (LED_WIDTH > 1) begin
            // A lit bit already at the far end (e.g. left there by a rotate) bounces instead of falling off.
            go_left      = (pp_state == PP_LEFT) ? !pattern[LED_WIDTH-1] : pattern[0];
            pattern_next = go_left ? (pattern << 1) : (pattern >> 1);
            if (pattern_next[LED_WIDTH-1])
              pp_state_next = PP_RIGHT;
            else if (pattern_next[0])
              pp_state_next = PP_LEFT;
            else
              pp_state_next = go_left ? PP_LEFT : PP_RIGHT;
          end
        end
        default: pattern_next = pattern;
      endcase
    end
  end

  assign bus.o_tick  = tick_q;
  assign bus.o_led   = (bus.i_color == 2'b00 || bus.i_color == 2'b11) ? pattern : '0;
  assign bus.o_led_b = (bus.i_color == 2'b01 || bus.i_color == 2'b11) ? pattern : '0;
  assign bus.o_led_g = (bus.i_color == 2'b10 || bus.i_color == 2'b11) ? pattern : '0;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed tick-by-tick table, multi-cycle corner
// sequences, and a randomized run checked every cycle against a behavioural model.
module tb_led_sequencer;
  localparam int LW   = 4;
  localparam int DW   = 4;
  localparam int FULL = (1 << LW) - 1;

  logic clock = 1'b0;
  logic i_reset;

  always #5 clock = ~clock;

  led_sequencer_if #(.LED_WIDTH(LW)) bus ();

  led_sequencer #(
    .LED_WIDTH (LW),
    .DATA_WIDTH(DW),
    .LIMIT0    (3),
    .LIMIT1    (5),
    .LIMIT2    (7),
    .LIMIT3    (15)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, wanted %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the lit LED is tracked as a position with a travel direction.
  int m_cnt;
  int m_tick;
  int m_pat;
  int m_dir;

  function automatic int limit_of(input int s);
    case (s)
      0:       return 3;
      1:       return 5;
      2:       return 7;
      default: return 15;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_tick = 0;
    m_pat  = 1;
    m_dir  = 1;
  endtask

  task automatic model_step(input int mode);
    int pos;
    if (mode == 3) begin
      m_pat = (m_pat == FULL) ? 0 : FULL;
    end else if ($countones(m_pat) != 1) begin
      m_pat = 1;
      m_dir = 1;
    end else if (mode == 0) begin
      m_pat = ((m_pat * 2) % (1 << LW)) + m_pat / (1 << (LW - 1));
    end else if (mode == 1) begin
      m_pat = m_pat / 2 + (m_pat % 2) * (1 << (LW - 1));
    end else begin
      pos = $clog2(m_pat);
      if (pos + m_dir < 0 || pos + m_dir > LW - 1) m_dir = -m_dir;
      pos = pos + m_dir;
      if (pos == LW - 1) m_dir = -1;
      if (pos == 0)      m_dir = 1;
      m_pat = 1 << pos;
    end
  endtask

  task automatic model_clock();
    if (bus.i_enable) begin
      if (m_cnt >= limit_of(int'(bus.i_speed))) begin
        m_tick = 1;
        m_cnt  = 0;
        model_step(int'(bus.i_mode));
      end else begin
        m_cnt++;
        m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    int c;
    c = int'(bus.i_color);
    check({tag, "_red"},   bus.o_led,   (c == 0 || c == 3) ? m_pat : 0);
    check({tag, "_blue"},  bus.o_led_b, (c == 1 || c == 3) ? m_pat : 0);
    check({tag, "_green"}, bus.o_led_g, (c == 2 || c == 3) ? m_pat : 0);
    check({tag, "_tick"},  bus.o_tick,  m_tick);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_clock();
    #1;
    compare_model("model");
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.o_tick && n < 40);
    check("tick_within_budget", bus.o_tick, 1);
  endtask

  // Called 1 ns after a rising edge: reset is low for 3 ns, well clear of the next edge.
  task automatic pulse_reset();
    #2;
    i_reset = 1'b0;
    #1;
    model_reset();
    compare_model("in_reset");
    #2;
    i_reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [1:0] color;
    logic [3:0] r;
    logic [3:0] b;
    logic [3:0] g;
  } vec_t;

  vec_t vecs[17];
  int   n;
  logic [3:0] led_hold;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'b00, 2'b00, 4'b0010, 4'b0000, 4'b0000};
    vecs[1]  = '{2'b00, 2'b00, 4'b0100, 4'b0000, 4'b0000};
    vecs[2]  = '{2'b00, 2'b00, 4'b1000, 4'b0000, 4'b0000};
    vecs[3]  = '{2'b00, 2'b00, 4'b0001, 4'b0000, 4'b0000};
    vecs[4]  = '{2'b10, 2'b11, 4'b0010, 4'b0010, 4'b0010};
    vecs[5]  = '{2'b10, 2'b11, 4'b0100, 4'b0100, 4'b0100};
    vecs[6]  = '{2'b10, 2'b11, 4'b1000, 4'b1000, 4'b1000};
    vecs[7]  = '{2'b10, 2'b11, 4'b0100, 4'b0100, 4'b0100};
    vecs[8]  = '{2'b10, 2'b11, 4'b0010, 4'b0010, 4'b0010};
    vecs[9]  = '{2'b10, 2'b11, 4'b0001, 4'b0001, 4'b0001};
    vecs[10] = '{2'b10, 2'b11, 4'b0010, 4'b0010, 4'b0010};
    vecs[11] = '{2'b11, 2'b01, 4'b0000, 4'b1111, 4'b0000};
    vecs[12] = '{2'b11, 2'b10, 4'b0000, 4'b0000, 4'b0000};
    vecs[13] = '{2'b00, 2'b00, 4'b0001, 4'b0000, 4'b0000};
    vecs[14] = '{2'b00, 2'b00, 4'b0010, 4'b0000, 4'b0000};
    vecs[15] = '{2'b01, 2'b10, 4'b0000, 4'b0000, 4'b0001};
    vecs[16] = '{2'b01, 2'b10, 4'b0000, 4'b0000, 4'b1000};

    i_reset      = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_speed  = 2'd0;
    bus.i_mode   = 2'b00;
    bus.i_color  = 2'b00;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    check("reset_red",   bus.o_led,   4'b0001);
    check("reset_blue",  bus.o_led_b, 4'b0000);
    check("reset_green", bus.o_led_g, 4'b0000);
    check("reset_tick",  bus.o_tick,  1'b0);
    i_reset = 1'b1;

    // Table: one entry per tick at speed 0; the interval must be 4 cycles every time.
    for (int i = 0; i < 17; i++) begin
      bus.i_mode  = vecs[i].mode;
      bus.i_color = vecs[i].color;
      wait_tick(n);
      check($sformatf("vec%0d_interval", i), n, 4);
      check($sformatf("vec%0d_red", i),   bus.o_led,   vecs[i].r);
      check($sformatf("vec%0d_blue", i),  bus.o_led_b, vecs[i].b);
      check($sformatf("vec%0d_green", i), bus.o_led_g, vecs[i].g);
    end

    // Speed drop mid-count: count 10 at limit 15, then limit 3 ticks on the next cycle.
    bus.i_mode  = 2'b00;
    bus.i_color = 2'b00;
    pulse_reset();
    bus.i_speed = 2'd3;
    repeat (10) cycle();
    bus.i_speed = 2'd0;
    cycle();
    check("speed_drop_tick", bus.o_tick, 1'b1);
    wait_tick(n);
    check("speed_drop_cleared_interval", n, 4);

    // Freeze for 20 cycles with 3 counts already done at limit 7, then finish the period.
    bus.i_speed = 2'd2;
    wait_tick(n);
    check("speed2_interval", n, 8);
    repeat (3) cycle();
    led_hold     = bus.o_led;
    bus.i_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("freeze_tick", bus.o_tick, 1'b0);
      check("freeze_led",  bus.o_led,  led_hold);
    end
    bus.i_enable = 1'b1;
    wait_tick(n);
    check("resume_remaining", n, 5);

    // Reset pulse between edges while ping-ponging on the way back down.
    bus.i_speed = 2'd0;
    pulse_reset();
    bus.i_mode = 2'b10;
    repeat (4) wait_tick(n);
    check("pp_before_reset", bus.o_led, 4'b0100);
    repeat (2) cycle();
    pulse_reset();
    check("pp_reset_led",  bus.o_led,  4'b0001);
    check("pp_reset_tick", bus.o_tick, 1'b0);
    wait_tick(n);
    check("pp_reset_interval", n, 4);
    check("pp_restart_led", bus.o_led, 4'b0010);
    wait_tick(n);
    check("pp_restart_led2", bus.o_led, 4'b0100);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      bus.i_enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) bus.i_speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) bus.i_mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3)  == 0) bus.i_color = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) pulse_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
